// File: rtl/iob_plic_src_cond.sv
// iob_plic_src_cond: per-source sync, polarity, debounce and edge/level shaping.
// Optional debounce is compiled in with IOB_PLIC_SRC_COND_DEBOUNCE_EN.
module iob_plic_src_cond #(
  parameter int N_SOURCES       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic [N_SOURCES-1:0] irq_raw_i,
  input  logic [N_SOURCES-1:0] cfg_pol_i,
  input  logic [N_SOURCES-1:0] cfg_edge_i,
  output logic [N_SOURCES-1:0] src_o
);

  logic [SYNC_STAGES-1:0][N_SOURCES-1:0] sync_q, sync_d;
  logic [N_SOURCES-1:0] act;
  logic [N_SOURCES-1:0] f_q, f_d, f_next;
  logic [N_SOURCES-1:0] src_q, src_d;

  // Shift raw lines through the synchronizer chain.
  always_comb begin
    sync_d = sync_q;
    if (cke_i) begin
      sync_d[0] = irq_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end
  end

  // Polarity is applied after the sync so a config flip acts at once.
  assign act = ~(sync_q[SYNC_STAGES-1] ^ cfg_pol_i);

`ifdef IOB_PLIC_SRC_COND_DEBOUNCE_EN
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_SOURCES-1:0][CW-1:0] cnt_q, cnt_d;

  // Accept a change only after it persists for DEBOUNCE_CYCLES cycles.
  always_comb begin
    f_next = f_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < N_SOURCES; i++) begin
      if (act[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        f_next[i] = act[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    if (!cke_i) begin
      cnt_d = cnt_q;
    end
  end

  // Debounce counters; reset drops any partial count.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without debounce the filtered state just follows the active level.
  always_comb begin
    f_next = act;
  end
`endif

  // Level mode passes the filtered state; edge mode pulses on rise only.
  always_comb begin
    f_d   = f_q;
    src_d = src_q;
    if (cke_i) begin
      f_d   = f_next;
      src_d = (cfg_edge_i & f_next & ~f_q) | (~cfg_edge_i & f_next);
    end
  end

  // Synchronizer, filtered state and output registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
      f_q    <= '0;
      src_q  <= '0;
    end else begin
      sync_q <= sync_d;
      f_q    <= f_d;
      src_q  <= src_d;
    end
  end

  assign src_o = src_q;

endmodule

// File: tb/tb_iob_plic_src_cond.sv
// tb_iob_plic_src_cond: directed table plus corner sequences.
// Tracks IOB_PLIC_SRC_COND_DEBOUNCE_EN to pick the expected latency.
module tb_iob_plic_src_cond;

  localparam int N  = 8;
  localparam int SS = 2;
`ifdef IOB_PLIC_SRC_COND_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  localparam int L = SS + D;

  logic         clk = 1'b0;
  logic         arst_i;
  logic         cke_i;
  logic [N-1:0] irq_raw_i;
  logic [N-1:0] cfg_pol_i;
  logic [N-1:0] cfg_edge_i;
  logic [N-1:0] src_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] pol;
    logic [7:0] edg;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[21];

  iob_plic_src_cond #(
    .N_SOURCES      (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i     (clk),
    .arst_i    (arst_i),
    .cke_i     (cke_i),
    .irq_raw_i (irq_raw_i),
    .cfg_pol_i (cfg_pol_i),
    .cfg_edge_i(cfg_edge_i),
    .src_o     (src_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] exp);
    checks++;
    if (src_o !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, src_o, exp);
    end
  endtask

  task automatic run(input logic [7:0] r, input logic [7:0] p,
                     input logic [7:0] e, input int n,
                     input logic [7:0] exp, input string nm);
    irq_raw_i  = r;
    cfg_pol_i  = p;
    cfg_edge_i = e;
    repeat (n) @(posedge clk);
    #1;
    chk(nm, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got none exp finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h08, 8'hFF, 8'h00, L-1, 8'h00};
    vecs[1]  = '{8'h08, 8'hFF, 8'h00, 1,   8'h08};
    vecs[2]  = '{8'h00, 8'hFF, 8'h00, L-1, 8'h08};
    vecs[3]  = '{8'h00, 8'hFF, 8'h00, 1,   8'h00};
    vecs[4]  = '{8'h01, 8'hFF, 8'h01, L,   8'h01};
    vecs[5]  = '{8'h01, 8'hFF, 8'h01, 1,   8'h00};
    vecs[6]  = '{8'h01, 8'hFF, 8'h01, 10,  8'h00};
    vecs[7]  = '{8'h00, 8'hFF, 8'h01, L,   8'h00};
    vecs[8]  = '{8'h00, 8'hDF, 8'h00, D-1, 8'h00};
    vecs[9]  = '{8'h00, 8'hDF, 8'h00, 1,   8'h20};
    vecs[10] = '{8'h00, 8'hFF, 8'h00, D-1, 8'h20};
    vecs[11] = '{8'h00, 8'hFF, 8'h00, 1,   8'h00};
    vecs[12] = '{8'hA5, 8'hFF, 8'h00, L,   8'hA5};
    vecs[13] = '{8'hA5, 8'h5A, 8'h00, D-1, 8'hA5};
    vecs[14] = '{8'hA5, 8'h5A, 8'h00, 1,   8'h00};
    vecs[15] = '{8'hFF, 8'hFF, 8'h00, L,   8'hFF};
    vecs[16] = '{8'hFF, 8'hFF, 8'hFF, 1,   8'h00};
    vecs[17] = '{8'hFF, 8'hFF, 8'h00, 1,   8'hFF};
    vecs[18] = '{8'h00, 8'hFF, 8'hFF, L,   8'h00};
    vecs[19] = '{8'h0F, 8'hFF, 8'hFF, L,   8'h0F};
    vecs[20] = '{8'h0F, 8'hFF, 8'hFF, 1,   8'h00};

    arst_i     = 1'b1;
    cke_i      = 1'b1;
    irq_raw_i  = 8'hFF;
    cfg_pol_i  = 8'hFF;
    cfg_edge_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", 8'h00);
    arst_i = 1'b0;
    repeat (L-1) @(posedge clk);
    #1;
    chk("rst_rel_early", 8'h00);
    @(posedge clk);
    #1;
    chk("rst_rel", 8'hFF);

    run(8'h00, 8'hFF, 8'h00, 2*L, 8'h00, "settle0");

    for (int v = 0; v < 21; v++) begin
      run(vecs[v].raw, vecs[v].pol, vecs[v].edg, vecs[v].n,
          vecs[v].exp, $sformatf("vec%0d", v));
    end

    run(8'h00, 8'hFF, 8'h01, 2*L, 8'h00, "cke_settle");
    run(8'h01, 8'hFF, 8'h01, L, 8'h01, "cke_pulse");
    cke_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("cke_hold", 8'h01);
    end
    cke_i = 1'b1;
    @(posedge clk);
    #1;
    chk("cke_clr", 8'h00);

`ifdef IOB_PLIC_SRC_COND_DEBOUNCE_EN
    run(8'h00, 8'hFF, 8'h00, 2*L, 8'h00, "glitch_settle");
    irq_raw_i = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    irq_raw_i = 8'h00;
    chk("glitch_in", 8'h00);
    for (int k = 0; k < 2*L; k++) begin
      @(posedge clk);
      #1;
      chk("glitch_out", 8'h00);
    end
    run(8'h00, 8'hFF, 8'h01, 2, 8'h00, "p4_settle");
    irq_raw_i = 8'h01;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) irq_raw_i = 8'h00;
      chk($sformatf("p4_c%0d", k), (k == SS + 4) ? 8'h01 : 8'h00);
    end
`else
    run(8'h00, 8'hFF, 8'h00, 2*L, 8'h00, "p1_settle");
    irq_raw_i = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) irq_raw_i = 8'h00;
      chk($sformatf("p1_c%0d", k), (k == L) ? 8'h01 : 8'h00);
    end
`endif

    run(8'hFF, 8'hFF, 8'h00, 2*L, 8'hFF, "ar_high");
    run(8'h00, 8'hFF, 8'h00, 1, 8'hFF, "ar_mid");
    arst_i = 1'b1;
    #1;
    chk("ar_async", 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("ar_held", 8'h00);
    arst_i    = 1'b0;
    irq_raw_i = 8'h01;
    repeat (L-1) @(posedge clk);
    #1;
    chk("ar_rel_early", 8'h00);
    @(posedge clk);
    #1;
    chk("ar_rel", 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_plic_src_cond.md
# iob_plic_src_cond

Interrupt source conditioner sitting directly upstream of the PLIC: takes raw, asynchronous per-source interrupt lines from peripherals or pads and produces clean, synchronous lines for the PLIC `src` inputs. Per source it performs multi-stage synchronization, polarity normalization, optional glitch debouncing and level-or-edge conversion. Edge mode emits a one-cycle pulse per active edge. Level mode emits a steady level that the PLIC gateway samples.

## Interface
Parameters:
- `N_SOURCES`, 8, number of interrupt sources (1..64)
- `SYNC_STAGES`, 2, synchronizer flops per source (>= 2)
- `DEBOUNCE_CYCLES`, 4, consecutive cycles a change must persist before acceptance (>= 1); used only with debounce compiled in

Ports:
- `clk_i` input 1, system clock
- `arst_i` input 1, asynchronous active-high reset
- `cke_i` input 1, clock enable; when low, every register holds
- `irq_raw_i` input N_SOURCES, raw asynchronous interrupt lines
- `cfg_pol_i` input N_SOURCES, per-source polarity; 1 = active-high, 0 = active-low
- `cfg_edge_i` input N_SOURCES, per-source mode; 1 = edge (pulse), 0 = level
- `src_o` output N_SOURCES, conditioned lines to PLIC `src`; registered

## Operation
Per source i, all bits independent.
- Synchronizer: shift register `sync[0..SYNC_STAGES-1]`, where `sync[0]` samples `irq_raw_i[i]`. The synchronized value is `s = sync[SYNC_STAGES-1]`.
- Normalize: `act = s XNOR cfg_pol_i[i]`. This is combinational, so a polarity change propagates without the synchronizer delay.
- Filtered state `f` (1 bit):
  - Without debounce: `f_next = act`.
  - With debounce: counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)` (min 1).
    - If `act == f`, then `cnt <= 0`.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, then `f <= act` and `cnt <= 0`.
    - Else `cnt <= cnt+1`.
    - A glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never reaches `f`.
- Output register:
  - Level mode: `src_o[i] <= f_next`.
  - Edge mode: `src_o[i] <= f_next & ~f`, a single-cycle pulse on the inactive-to-active transition only.
  - An active-to-inactive transition produces no pulse in edge mode.
- Config changes:
  - `cfg_edge_i` is sampled combinationally each cycle. Switching level to edge while `f = 1` drops `src_o` to 0 next cycle with no pulse. Switching edge to level while `f = 1` raises `src_o` next cycle.
  - `cfg_pol_i` change flips `act` and is treated as an ordinary transition, subject to debounce and able to produce an edge pulse.
- Reset: `sync`, `f`, `cnt` and `src_o` all clear to 0, so `src_o` = 0 during and after reset.
  - An active-low source whose raw line is low at reset release asserts after normal latency.
  - Reset mid-debounce discards the partial count.

## Timing
- All state updates on rising `clk_i` when `cke_i = 1`. `arst_i` acts immediately, independent of clock.
- Let D = `DEBOUNCE_CYCLES`, or D = 1 when debounce is compiled out. If raw changes and meets setup before rising edge 1, `src_o` reflects it after rising edge `SYNC_STAGES + D`.
- Defaults: no debounce gives 3 cycles; debounce gives 6 cycles.
- Edge pulse width: exactly 1 `cke_i`-qualified cycle. Pulses held by `cke_i = 0` stay high until the next enabled edge.
- Minimum distinguishable pulse on `irq_raw_i`: 1 cycle without debounce, D cycles with it. Shorter inputs are not guaranteed to be seen.
- Back-to-back edges: an active-inactive-active sequence needs at least `2*D` cycles to yield two pulses.
- No combinational path from any input to `src_o`.

## Configuration
- Macro `IOB_PLIC_SRC_COND_DEBOUNCE_EN`.
- Defined: per-source debounce counters instantiated and `DEBOUNCE_CYCLES` honoured.
- Undefined: no counters, `f_next = act`, latency `SYNC_STAGES + 1`, and `DEBOUNCE_CYCLES` ignored.

## Test plan
- Reset: hold `arst_i = 1` with `irq_raw_i = 8'hFF`, `cfg_pol_i = 8'hFF` -> `src_o = 8'h00`. Release reset -> `src_o = 8'hFF` exactly 3 cycles later (no debounce) or 6 cycles later (debounce).
- Level mode, active-high, source 3: raw rises, held 10 cycles, falls -> `src_o[3]` high for 10 cycles, delayed by latency; other bits 0.
- Edge mode, source 0: raw high for 20 cycles -> exactly one 1-cycle pulse on `src_o[0]`, and no pulse on the falling edge.
- Polarity: `cfg_pol_i[5] = 0` with raw low -> `src_o[5] = 1`. Flip `cfg_pol_i[5]` to 1 -> `src_o[5] = 0` after D cycles.
- Debounce (macro on, D = 4): a 3-cycle raw glitch gives no `src_o` change. A 4-cycle pulse in edge mode gives one pulse at cycle `SYNC_STAGES + 4`.
- `cke_i = 0` for 5 cycles during an edge pulse -> `src_o` holds at 1 and clears one enabled cycle after `cke_i` returns. Async reset asserted mid-debounce -> all outputs 0 and the count is discarded.
